// File: rtl/axi_lite_read_arbiter.sv
// Two-master AXI4-lite read arbiter with one read outstanding and a watchdog that aborts when the slave stops answering.
// The address path adds 1 cycle and read data is registered. A master holding rready low keeps RESP and blocks new grants.
module axi_lite_read_arbiter #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter bit                FIXED_PRIORITY = 1'b0,
    parameter int                TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [2:0]        m0_arprot,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [2:0]        m1_arprot,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [2:0]        s_arprot,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              busy,
    output logic              timeout_pulse
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam int            TW     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit            WD_EN  = (TIMEOUT_CYCLES > 0);

    logic [1:0]        state;
    logic              last_grant;
    logic              owner;
    logic [TW-1:0]     timer;
    logic              win;
    logic              ar_hs;
    logic              stage_done;
    logic              expire;
    logic              resp_load;
    logic [DATA_W-1:0] resp_data;
    logic              owner_rready;

    // A tie goes to m0 in fixed mode, otherwise to whoever was not served last.
    always_comb begin
        win = m1_arvalid;
        if (m0_arvalid && m1_arvalid) begin
            win = FIXED_PRIORITY ? 1'b0 : ~last_grant;
        end
    end

    assign m0_arready = !reset && (state == IDLE) && m0_arvalid && !win;
    assign m1_arready = !reset && (state == IDLE) && m1_arvalid && win;
    assign ar_hs      = m0_arready || m1_arready;
    assign s_rready   = !reset && (state != RESP);
    assign busy       = (state != IDLE);

    assign stage_done = ((state == ADDR) && s_arvalid && s_arready) ||
                        ((state == DATA) && s_rvalid && s_rready);
    // A handshake landing on the last allowed cycle beats the abort.
    assign expire     = WD_EN && ((state == ADDR) || (state == DATA)) &&
                        (timer == T_LAST) && !stage_done;

    assign resp_load    = ((state == DATA) && stage_done) || expire;
    assign resp_data    = expire ? TIMEOUT_DATA : s_rdata;
    assign owner_rready = owner ? m1_rready : m0_rready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            timer         <= '0;
            s_arvalid     <= 1'b0;
            s_araddr      <= '0;
            s_arprot      <= '0;
            m0_rvalid     <= 1'b0;
            m1_rvalid     <= 1'b0;
            m0_rdata      <= '0;
            m1_rdata      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= expire;

            if (resp_load) begin
                m0_rvalid <= !owner;
                m1_rvalid <= owner;
                m0_rdata  <= owner ? '0 : resp_data;
                m1_rdata  <= owner ? resp_data : '0;
            end else if ((state == RESP) && owner_rready) begin
                m0_rvalid <= 1'b0;
                m1_rvalid <= 1'b0;
                m0_rdata  <= '0;
                m1_rdata  <= '0;
            end

            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        owner      <= win;
                        last_grant <= win;
                        s_araddr   <= win ? m1_araddr : m0_araddr;
                        s_arprot   <= win ? m1_arprot : m0_arprot;
                        s_arvalid  <= 1'b1;
                        timer      <= '0;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    timer <= timer + TW'(1);
                    if (stage_done) begin
                        s_arvalid <= 1'b0;
                        state     <= DATA;
                    end else if (expire) begin
                        s_arvalid <= 1'b0;
                        state     <= RESP;
                    end
                end
                DATA: begin
                    timer <= timer + TW'(1);
                    if (resp_load) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (owner_rready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// Bench for axi_lite_read_arbiter: round-robin DUT with a wait-state slave model, plus a fixed-priority DUT on an always-ready slave.
module tb_axi_lite_read_arbiter;

    localparam int          TO       = 8;
    localparam logic [31:0] UNMAPPED = 32'h0004_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_arvalid = 1'b0, m0_arready, m0_rvalid, m0_rready = 1'b0;
    logic [31:0] m0_araddr = '0, m0_rdata;
    logic [2:0]  m0_arprot = '0;
    logic        m1_arvalid = 1'b0, m1_arready, m1_rvalid, m1_rready = 1'b0;
    logic [31:0] m1_araddr = '0, m1_rdata;
    logic [2:0]  m1_arprot = '0;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, busy, timeout_pulse;
    logic [31:0] s_araddr, s_rdata;
    logic [2:0]  s_arprot;

    logic        f_m0_arvalid = 1'b0, f_m0_arready, f_m0_rvalid, f_m0_rready = 1'b0;
    logic        f_m1_arvalid = 1'b0, f_m1_arready, f_m1_rvalid, f_m1_rready = 1'b0;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_s_araddr;
    logic [2:0]  f_s_arprot;
    logic        f_s_arvalid, f_s_rready, f_busy, f_timeout_pulse;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit lg = 1'b1;
    int gwait;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_lite_read_arbiter #(.FIXED_PRIORITY(1'b0), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arprot(m0_arprot),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arprot(m1_arprot),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .busy(busy), .timeout_pulse(timeout_pulse)
    );

    axi_lite_read_arbiter #(.FIXED_PRIORITY(1'b1), .TIMEOUT_CYCLES(TO)) fdut (
        .clk(clk), .reset(reset),
        .m0_arvalid(f_m0_arvalid), .m0_arready(f_m0_arready), .m0_araddr(32'h0000_0040), .m0_arprot(3'd0),
        .m0_rvalid(f_m0_rvalid), .m0_rready(f_m0_rready), .m0_rdata(f_m0_rdata),
        .m1_arvalid(f_m1_arvalid), .m1_arready(f_m1_arready), .m1_araddr(32'h0000_0050), .m1_arprot(3'd1),
        .m1_rvalid(f_m1_rvalid), .m1_rready(f_m1_rready), .m1_rdata(f_m1_rdata),
        .s_arvalid(f_s_arvalid), .s_arready(1'b1), .s_araddr(f_s_araddr), .s_arprot(f_s_arprot),
        .s_rvalid(1'b1), .s_rready(f_s_rready), .s_rdata(32'hCAFE_0000),
        .busy(f_busy), .timeout_pulse(f_timeout_pulse)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h1234_5678;
        return (a ^ 32'hA5A5_0000) + 32'h0000_1357;
    endfunction

    // Slave: ar_wait cycles before arready, r_wait cycles before rvalid, never answers unmapped reads.
    int          ar_wait = 0, r_wait = 0, ar_cnt = 0, r_cnt = 0;
    bit          pend = 1'b0;
    logic [31:0] raddr = '0;
    assign s_arready = s_arvalid && (ar_cnt >= ar_wait);
    assign s_rvalid  = pend && (r_cnt >= r_wait) && (raddr < UNMAPPED);
    assign s_rdata   = s_rvalid ? mem_fn(raddr) : 32'h0;

    always @(posedge clk) begin
        if (reset) begin
            ar_cnt <= 0; r_cnt <= 0; pend <= 1'b0; raddr <= '0;
        end else begin
            ar_cnt <= (s_arvalid && !s_arready) ? ar_cnt + 1 : 0;
            if (s_arvalid && s_arready) begin
                pend <= 1'b1; r_cnt <= 0; raddr <= s_araddr;
            end else if (s_rvalid && s_rready) begin
                pend <= 1'b0;
            end else if (pend) begin
                r_cnt <= r_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_winner(input bit v0, input bit v1);
        if (v0 && v1) return !lg;
        return v1;
    endfunction

    task automatic do_reset();
        logic v;
        v = m0_arvalid;
        m0_arvalid = 1'b1;
        reset = 1'b1;
        @(negedge clk); #1;
        chk("reset_ctrl", {busy, timeout_pulse, s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}, 0);
        chk("reset_addr", {s_araddr, s_arprot}, 0);
        chk("reset_rdata", {m0_rdata, m1_rdata}, 0);
        m0_arvalid = v;
        reset = 1'b0;
        lg = 1'b1;
        #1;
    endtask

    // One transaction: checks the grant against the model, the latency, the data, the timeout and the release.
    task automatic run_txn(input int hold, input bit drop, input bit raise_other);
        bit got, w, ab, tp_seen;
        logic [31:0] a, ed;
        logic [2:0] p;
        int t0, tp_lat, bad;
        got = 1'b0; gwait = 0; tp_seen = 1'b0; tp_lat = 0; bad = 0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (m0_arready || m1_arready) begin got = 1'b1; break; end
            gwait++;
            @(negedge clk); #1;
        end
        chk("grant_seen", got, 1);
        if (!got) return;
        w = m1_arready;
        chk("one_winner", m0_arready & m1_arready, 0);
        chk("winner", w, exp_winner(m0_arvalid, m1_arvalid));
        lg = w;
        a  = w ? m1_araddr : m0_araddr;
        p  = w ? m1_arprot : m0_arprot;
        ab = (a >= UNMAPPED) || (ar_wait + r_wait + 2 > TO);
        ed = ab ? 32'hDEAD_BEEF : mem_fn(a);
        t0 = cyc;
        @(negedge clk); #1;
        chk("s_ar_out", {s_arvalid, busy, s_arprot, s_araddr}, {1'b1, 1'b1, p, a});
        if (drop) begin if (w) m1_arvalid = 1'b0; else m0_arvalid = 1'b0; end
        if (raise_other) begin if (w) m0_arvalid = 1'b1; else m1_arvalid = 1'b1; end
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (timeout_pulse && !tp_seen) begin tp_seen = 1'b1; tp_lat = cyc - t0; end
            if (m0_arready || m1_arready) bad++;
            if (w ? m1_rvalid : m0_rvalid) begin got = 1'b1; break; end
            if (w ? (m0_rvalid || m0_rdata != 0) : (m1_rvalid || m1_rdata != 0)) bad++;
        end
        chk("rvalid_seen", got, 1);
        if (!got) return;
        chk("latency", cyc - t0, ab ? TO + 1 : ar_wait + r_wait + 3);
        chk("tpulse_seen", tp_seen, ab);
        if (ab) chk("tpulse_lat", tp_lat, TO + 1);
        chk("rdata", w ? m1_rdata : m0_rdata, ed);
        chk("other_zero", w ? {m0_rvalid, m0_rdata} : {m1_rvalid, m1_rdata}, 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk); #1;
            if ((w ? m1_rvalid : m0_rvalid) !== 1'b1 || (w ? m1_rdata : m0_rdata) !== ed) bad++;
            if (s_rready || m0_arready || m1_arready || !busy || timeout_pulse) bad++;
        end
        chk("busy_stable", bad, 0);
        if (w) m1_rready = 1'b1; else m0_rready = 1'b1;
        @(negedge clk);
        m0_rready = 1'b0; m1_rready = 1'b0;
        #1;
        chk("release", {busy, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata}, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 5) == 0) return UNMAPPED + ($urandom & 32'h0000_0FFC);
        return $urandom & 32'h0003_FFFC;
    endfunction

    initial begin
        int g0, g1, bad;
        @(negedge clk); #1;
        do_reset();

        // Single m0 read with a zero-wait slave.
        m0_araddr = 32'h0000_0010; m0_arprot = 3'd3; m0_arvalid = 1'b1;
        run_txn(0, 1'b1, 1'b0);

        // Back-to-back round robin from reset: m0, m1, m0, m1.
        do_reset();
        m0_araddr = 32'h0000_0020; m1_araddr = 32'h0000_0030; m1_arprot = 3'd5;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        for (int i = 0; i < 4; i++) run_txn(0, 1'b0, 1'b0);
        m0_arvalid = 1'b0; m1_arvalid = 1'b0; #1;

        // m0 requests while m1 is outstanding and is granted in the following IDLE cycle.
        m1_araddr = 32'h0000_0044; m0_araddr = 32'h0000_0048; m1_arvalid = 1'b1;
        run_txn(0, 1'b1, 1'b1);
        run_txn(0, 1'b1, 1'b0);
        chk("next_grant_idle", gwait, 0);

        // Unmapped read times out; then an m0 read held in RESP for 5 cycles.
        m1_araddr = UNMAPPED; m1_arvalid = 1'b1;
        run_txn(0, 1'b1, 1'b0);
        m0_araddr = 32'h0000_0100; m0_arvalid = 1'b1;
        run_txn(5, 1'b1, 1'b0);

        // Watchdog boundaries: completion on the expiry cycle, one cycle late, and a stuck address phase.
        ar_wait = 3; r_wait = 3; m0_araddr = 32'h0000_0104; m0_arvalid = 1'b1;
        run_txn(0, 1'b1, 1'b0);
        ar_wait = 4; r_wait = 3; m1_araddr = 32'h0000_0108; m1_arvalid = 1'b1;
        run_txn(1, 1'b1, 1'b0);
        ar_wait = 8; r_wait = 0; m0_araddr = 32'h0000_010C; m0_arvalid = 1'b1;
        run_txn(0, 1'b1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            if (!m0_arvalid && $urandom_range(0, 1) == 1) begin
                m0_arvalid = 1'b1; m0_araddr = rand_addr(); m0_arprot = 3'($urandom_range(0, 7));
            end
            if (!m1_arvalid && $urandom_range(0, 1) == 1) begin
                m1_arvalid = 1'b1; m1_araddr = rand_addr(); m1_arprot = 3'($urandom_range(0, 7));
            end
            if (!m0_arvalid && !m1_arvalid) begin
                m0_arvalid = 1'b1; m0_araddr = rand_addr();
            end
            ar_wait = $urandom_range(0, 4);
            r_wait  = $urandom_range(0, 4);
            run_txn($urandom_range(0, 3), 1'b1, 1'b0);
        end
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        @(negedge clk); @(negedge clk); #1;

        // Reset while in DATA, then a clean read.
        ar_wait = 0; r_wait = 15; m0_araddr = 32'h0000_0080; m0_arvalid = 1'b1;
        #1;
        chk("t6_grant", m0_arready, 1);
        @(negedge clk); #1;
        m0_arvalid = 1'b0;
        @(negedge clk); #1;
        chk("t6_in_data", {busy, s_arvalid}, 2'b10);
        do_reset();
        r_wait = 1; m0_araddr = 32'h0001_0000; m0_arvalid = 1'b1;
        run_txn(0, 1'b1, 1'b0);
        m0_arvalid = 1'b0; #1;

        // Fixed priority: m0 wins every tie, one grant every 4 cycles.
        g0 = 0; g1 = 0; bad = 0;
        f_m0_rready = 1'b1; f_m1_rready = 1'b1;
        f_m0_arvalid = 1'b1; f_m1_arvalid = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            g0 += int'(f_m0_arready);
            g1 += int'(f_m1_arready);
            if (f_m0_rvalid && f_m0_rdata !== 32'hCAFE_0000) bad++;
            if (f_m1_rvalid) bad++;
            @(negedge clk); #1;
        end
        chk("fixed_m0_grants", g0, 5);
        chk("fixed_m1_grants", g1, 0);
        chk("fixed_resp", bad, 0);
        f_m0_arvalid = 1'b0; f_m1_arvalid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
